// File: rtl/lcd_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_bus_sequencer                                                        |
// | 4-bit LCD1602 bus owner: power-up/init sequence, then round-robin byte   |
// | transfers from two requesters with counted nibble phases and busy waits. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_bus_sequencer #(
  parameter int PWRUP_WAIT = 15000,
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 8,
  parameter int HOLD_CYC   = 2,
  parameter int CMD_WAIT   = 40,
  parameter int CLR_WAIT   = 1600
) (
  input  logic       clk_LCD,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  output logic       ack0,
  output logic       ack1,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  localparam int c_NIB_LEN = SETUP_CYC + EN_CYC + HOLD_CYC;
  localparam int c_MAX_A   = (PWRUP_WAIT > CLR_WAIT) ? PWRUP_WAIT : CLR_WAIT;
  localparam int c_MAX_B   = (CMD_WAIT > c_NIB_LEN) ? CMD_WAIT : c_NIB_LEN;
  localparam int c_CNT_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CW      = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CW-1:0] c_PWR_LAST = c_CW'(PWRUP_WAIT - 1);
  localparam logic [c_CW-1:0] c_NIB_LAST = c_CW'(c_NIB_LEN - 1);
  localparam logic [c_CW-1:0] c_CMD_LAST = c_CW'(CMD_WAIT - 1);
  localparam logic [c_CW-1:0] c_CLR_LAST = c_CW'(CLR_WAIT - 1);
  localparam logic [c_CW-1:0] c_EN_FIRST = c_CW'(SETUP_CYC);
  localparam logic [c_CW-1:0] c_EN_LAST  = c_CW'(SETUP_CYC + EN_CYC - 1);

  localparam logic [2:0] c_ST_PWR  = 3'd0;
  localparam logic [2:0] c_ST_IDLE = 3'd1;
  localparam logic [2:0] c_ST_HI   = 3'd2;
  localparam logic [2:0] c_ST_LO   = 3'd3;
  localparam logic [2:0] c_ST_WAIT = 3'd4;

  logic [2:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_step;
  logic [7:0]      r_byte;
  logic            r_rs;
  logic            r_single;
  logic            r_init_done;
  logic            r_last;

  logic [7:0]      w_step_byte;
  logic            w_step_single;
  logic            w_wait_clr;
  logic [c_CW-1:0] w_wait_last;
  logic            w_arb0;
  logic            w_can_grant;
  logic            w_nib;

  // Init steps 0..3 are lone high nibbles (0x3,0x3,0x3,0x2); 4..7 are full bytes.
  always_comb begin
    w_step_byte = 8'h30;
    case (r_step)
      4'd3:    w_step_byte = 8'h20;
      4'd4:    w_step_byte = 8'h28;
      4'd5:    w_step_byte = 8'h0C;
      4'd6:    w_step_byte = 8'h01;
      4'd7:    w_step_byte = 8'h06;
      default: w_step_byte = 8'h30;
    endcase
  end
  assign w_step_single = (r_step < 4'd4);

  // A lone 0x3 nibble needs the long wait, a lone 0x2 the short one.
  assign w_wait_clr  = r_single ? r_byte[4]
                                : (!r_rs && (r_byte[7:2] == 6'd0) && (r_byte != 8'd0));
  assign w_wait_last = w_wait_clr ? c_CLR_LAST : c_CMD_LAST;

  assign w_can_grant = (r_state == c_ST_IDLE) && r_init_done;
  assign w_arb0      = req0 && (!req1 || r_last);
  assign ack0        = w_can_grant && w_arb0;
  assign ack1        = w_can_grant && req1 && !w_arb0;

  assign w_nib     = (r_state == c_ST_HI) || (r_state == c_ST_LO);
  assign lcd_data  = (r_state == c_ST_HI) ? r_byte[7:4] :
                     (r_state == c_ST_LO) ? r_byte[3:0] : 4'h0;
  assign lcd_rs    = w_nib && r_rs;
  assign lcd_en    = w_nib && (r_cnt >= c_EN_FIRST) && (r_cnt <= c_EN_LAST);
  assign lcd_rw    = 1'b0;
  assign init_done = r_init_done;
  assign busy      = (r_state != c_ST_IDLE);

  always_ff @(posedge clk_LCD or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_PWR;
      r_cnt       <= '0;
      r_step      <= 4'd0;
      r_byte      <= 8'd0;
      r_rs        <= 1'b0;
      r_single    <= 1'b0;
      r_init_done <= 1'b0;
      r_last      <= 1'b1;
    end else begin
      case (r_state)
        c_ST_PWR: begin
          if (r_cnt == c_PWR_LAST) begin
            r_cnt    <= '0;
            r_state  <= c_ST_HI;
            r_byte   <= w_step_byte;
            r_single <= w_step_single;
            r_rs     <= 1'b0;
            r_step   <= r_step + 4'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_IDLE: begin
          if (ack0) begin
            r_byte   <= byte0;
            r_rs     <= rs0;
            r_single <= 1'b0;
            r_last   <= 1'b0;
            r_state  <= c_ST_HI;
          end else if (ack1) begin
            r_byte   <= byte1;
            r_rs     <= rs1;
            r_single <= 1'b0;
            r_last   <= 1'b1;
            r_state  <= c_ST_HI;
          end
        end
        c_ST_HI: begin
          if (r_cnt == c_NIB_LAST) begin
            r_cnt   <= '0;
            r_state <= r_single ? c_ST_WAIT : c_ST_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_LO: begin
          if (r_cnt == c_NIB_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ST_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt <= '0;
            if (r_init_done) begin
              r_state <= c_ST_IDLE;
            end else if (r_step == 4'd8) begin
              r_init_done <= 1'b1;
              r_state     <= c_ST_IDLE;
            end else begin
              r_state  <= c_ST_HI;
              r_byte   <= w_step_byte;
              r_single <= w_step_single;
              r_rs     <= 1'b0;
              r_step   <= r_step + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= c_ST_PWR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_bus_sequencer                                                     |
// | Per-cycle comparison against an expected-waveform queue model.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lcd_bus_sequencer;
  localparam int PW = 20, SU = 1, EN = 2, HO = 1, CW = 4, LW = 10;
  localparam int NL = SU + EN + HO;
  localparam logic [3:0] INIT_NIBS [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                           4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

  logic clk_LCD = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, rs0 = 1'b0, rs1 = 1'b0;
  logic [7:0] byte0 = 8'd0, byte1 = 8'd0;
  logic ack0, ack1, lcd_en, lcd_rs, lcd_rw, init_done, busy;
  logic [3:0] lcd_data;

  lcd_bus_sequencer #(
    .PWRUP_WAIT(PW), .SETUP_CYC(SU), .EN_CYC(EN), .HOLD_CYC(HO),
    .CMD_WAIT(CW), .CLR_WAIT(LW)
  ) dut (
    .clk_LCD(clk_LCD), .rst_n(rst_n), .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1),
    .byte0(byte0), .byte1(byte1), .ack0(ack0), .ack1(ack1), .lcd_en(lcd_en),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .init_done(init_done),
    .busy(busy)
  );

  always #5 clk_LCD = ~clk_LCD;

  int checks = 0, errors = 0;
  int cyc;

  always @(posedge clk_LCD or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: one queue entry per busy cycle; an empty queue means the bus is idle.
  typedef struct packed {
    logic       en;
    logic       nib;
    logic       rs;
    logic       ini;
    logic [3:0] d;
  } exp_t;

  exp_t q[$];
  bit   m_last;

  function automatic void push_nib(input logic rs, input logic [3:0] d, input logic ini);
    exp_t e;
    for (int i = 0; i < NL; i++) begin
      e.en = (i >= SU) && (i < SU + EN); e.nib = 1'b1; e.rs = rs; e.d = d; e.ini = ini;
      q.push_back(e);
    end
  endfunction

  function automatic void push_wait(input int w, input logic ini);
    exp_t e;
    for (int i = 0; i < w; i++) begin
      e.en = 1'b0; e.nib = 1'b0; e.rs = 1'b0; e.d = 4'h0; e.ini = ini;
      q.push_back(e);
    end
  endfunction

  function automatic int wait_for(input logic rs, input logic [7:0] b);
    return (!rs && b >= 8'd1 && b <= 8'd3) ? LW : CW;
  endfunction

  function automatic void push_byte(input logic rs, input logic [7:0] b, input logic ini);
    push_nib(rs, b[7:4], ini);
    push_nib(rs, b[3:0], ini);
    push_wait(wait_for(rs, b), ini);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_last = 1'b1;
    push_wait(PW, 1'b1);
    for (int k = 0; k < 3; k++) begin
      push_nib(1'b0, 4'h3, 1'b1);
      push_wait(LW, 1'b1);
    end
    push_nib(1'b0, 4'h2, 1'b1);
    push_wait(CW, 1'b1);
    push_byte(1'b0, 8'h28, 1'b1);
    push_byte(1'b0, 8'h0C, 1'b1);
    push_byte(1'b0, 8'h01, 1'b1);
    push_byte(1'b0, 8'h06, 1'b1);
  endfunction

  exp_t cur;
  bit   g0, g1;

  always @(negedge clk_LCD) begin
    if (!rst_n) begin
      chk("rst_en", lcd_en, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      chk("rst_ack", {ack0, ack1}, 0);
      model_reset();
    end else begin
      chk("rw", lcd_rw, 0);
      if (q.size() == 0) begin
        g0 = req0 && (!req1 || m_last);
        g1 = req1 && !g0;
        chk("idle_busy", busy, 0);
        chk("idle_en", lcd_en, 0);
        chk("idle_init_done", init_done, 1);
        chk("ack0", ack0, g0);
        chk("ack1", ack1, g1);
        if (g0) begin m_last = 1'b0; push_byte(rs0, byte0, 1'b0); end
        else if (g1) begin m_last = 1'b1; push_byte(rs1, byte1, 1'b0); end
      end else begin
        cur = q.pop_front();
        chk("busy", busy, 1);
        chk("en", lcd_en, cur.en);
        chk("init_done", init_done, !cur.ini);
        chk("busy_ack", {ack0, ack1}, 0);
        if (cur.nib) begin
          chk("rs", lcd_rs, cur.rs);
          chk("data", lcd_data, cur.d);
        end
      end
    end
  end

  // Observations of the DUT used by the hand-computed expectations below.
  logic [3:0] nibs[$];
  logic       nib_rs[$];
  bit         pen = 1'b0, pid = 1'b0;
  int         first_en = -1, idone_cyc = -1;

  always @(negedge clk_LCD) begin
    if (!rst_n) begin
      nibs.delete(); nib_rs.delete();
      pen = 1'b0; pid = 1'b0; first_en = -1; idone_cyc = -1;
    end else begin
      if (lcd_en && !pen) begin
        if (nibs.size() == 0) first_en = cyc;
        nibs.push_back(lcd_data);
        nib_rs.push_back(lcd_rs);
      end
      if (init_done && !pid) idone_cyc = cyc;
      pen = lcd_en;
      pid = init_done;
    end
  end

  task automatic wait_ack(input int who, input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim && at < 0; i++) begin
      @(negedge clk_LCD);
      if ((who == 0 && ack0) || (who == 1 && ack1)) at = cyc;
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL ack%0d_timeout: got none, expected ack within %0d cycles", who, lim);
    end
    @(posedge clk_LCD); #1;
  endtask

  task automatic check_init();
    logic any_rs;
    any_rs = 1'b0;
    chk("first_en_cycle", first_en, PW + SU);
    chk("init_done_cycle", idone_cyc, 124);
    chk("init_nib_count_ok", nibs.size() >= 12, 1);
    for (int i = 0; i < 12; i++) begin
      if (i < nibs.size()) begin
        chk($sformatf("init_nib%0d", i), nibs[i], INIT_NIBS[i]);
        any_rs = any_rs | nib_rs[i];
      end
    end
    chk("init_rs", any_rs, 0);
  endtask

  int a1, a2, b1, b2, b3, at, who;
  bit s0, s1;

  initial begin
    // Reset, with requester 0 already waiting through the whole init sequence.
    req0 = 1'b1; rs0 = 1'b1; byte0 = 8'h4B;
    repeat (3) @(posedge clk_LCD);
    #1 rst_n = 1'b1;

    wait_ack(0, 200, a1);
    chk("first_ack_cycle", a1, 124);
    byte0 = 8'hA5;
    wait_ack(0, 100, a2);
    chk("data_spacing", a2 - a1, 13);
    req0 = 1'b0;
    check_init();
    if (nibs.size() >= 14) begin
      chk("single_hi", nibs[12], 4'h4);
      chk("single_lo", nibs[13], 4'hB);
      chk("single_rs", nib_rs[12] & nib_rs[13], 1);
    end

    // Clear byte then a normal command byte from requester 1.
    req1 = 1'b1; rs1 = 1'b0; byte1 = 8'h01;
    wait_ack(1, 100, b1);
    byte1 = 8'h06;
    wait_ack(1, 100, b2);
    chk("clear_spacing", b2 - b1, 19);
    byte1 = 8'h33;
    wait_ack(1, 100, b3);
    chk("cmd_spacing", b3 - b2, 13);
    req1 = 1'b0;

    // Random traffic from both requesters.
    for (int i = 0; i < 900; i++) begin
      @(negedge clk_LCD); s0 = ack0; s1 = ack1;
      @(posedge clk_LCD); #1;
      if (!req0 || s0) begin
        req0 = ($urandom_range(0, 2) != 0); rs0 = 1'($urandom_range(0, 1));
        byte0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      end
      if (!req1 || s1) begin
        req1 = ($urandom_range(0, 2) != 0); rs1 = 1'($urandom_range(0, 1));
        byte1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk_LCD); s0 = ack0; s1 = ack1;
    @(posedge clk_LCD); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(posedge clk_LCD);
    #1;

    // Reset while lcd_en is high.
    req0 = 1'b1; rs0 = 1'b1; byte0 = 8'($urandom_range(0, 255));
    s0 = 1'b0;
    for (int i = 0; i < 100 && !s0; i++) begin
      @(negedge clk_LCD); s0 = lcd_en;
    end
    chk("en_seen_before_reset", s0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", lcd_en, 0);
    chk("async_rs", lcd_rs, 0);
    chk("async_data", lcd_data, 0);
    chk("async_init_done", init_done, 0);
    chk("async_busy", busy, 1);
    req0 = 1'b1; req1 = 1'b1; rs0 = 1'b1; rs1 = 1'b1; byte0 = 8'h5A; byte1 = 8'hC3;
    repeat (2) @(posedge clk_LCD);
    #1 rst_n = 1'b1;

    // Round-robin with both requests held continuously.
    for (int k = 0; k < 4; k++) begin
      who = -1; at = -1;
      for (int i = 0; i < 300 && who < 0; i++) begin
        @(negedge clk_LCD);
        if (ack0) who = 0;
        else if (ack1) who = 1;
        at = cyc;
      end
      chk($sformatf("rr_order%0d", k), who, k % 2);
      if (k == 0) chk("reinit_first_ack", at, 124);
      @(posedge clk_LCD); #1;
      if (who == 0) byte0 = 8'($urandom_range(0, 255));
      else if (who == 1) byte1 = 8'($urandom_range(0, 255));
    end
    check_init();
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(posedge clk_LCD);
    repeat (2) @(posedge clk_LCD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
